uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, is the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, is the serial bit rate in bits/s.
REQ-003 Parameter OVERSAMPLE, default 16, is the number of sample ticks per bit period.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-006 RxD  input  1  asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-007 data  output  8  last correctly received byte.
REQ-008 data_valid  output  1  one-cycle pulse: new byte on data.
REQ-009 framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 busy  output  1  high from start-bit detection until the frame is finished.

Function
REQ-011 RxD SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (rx_s).
REQ-012 Tick generator: counter SHALL count 0..DIV-1, DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (integer floor, minimum 1), and SHALL emit a one-cycle tick at DIV-1.
REQ-013 Tick counter SHALL run freely and SHALL be cleared to 0 when the FSM leaves IDLE, so frame timing is aligned to the start edge.
REQ-014 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: on rx_s == 0 SHALL go to START, clear the sample counter, and assert busy.
REQ-016 START: at tick count OVERSAMPLE/2 (mid start bit), rx_s == 0 -> DATA; rx_s == 1 -> IDLE (glitch rejected, no output pulse, busy falls).
REQ-017 DATA: every OVERSAMPLE ticks (mid bit) SHALL sample rx_s into a shift register, LSB first; after the 8th sample -> STOP.
REQ-018 Bit counter SHALL be 3 bits wide and wrap 7 -> 0 exactly at the DATA -> STOP transition.
REQ-019 STOP: at mid stop bit, rx_s == 1 -> data <= shift register, data_valid = 1 for one clk, -> IDLE.
REQ-020 STOP: at mid stop bit, rx_s == 0 -> framing_error = 1 for one clk, data unchanged, -> WAIT_IDLE.
REQ-021 WAIT_IDLE: SHALL stay until rx_s == 1 (break/line-low protection), then -> IDLE; busy SHALL stay high throughout.
REQ-022 busy SHALL be 0 only in IDLE.
REQ-023 data_valid and framing_error SHALL never be asserted in the same cycle and SHALL never last more than one clk.
REQ-024 data SHALL hold its value until the next data_valid.
REQ-025 Latency: data_valid SHALL rise within 9.5 bit periods + 3 clk of the RxD falling start edge.
REQ-026 A falling edge on RxD outside IDLE SHALL be ignored (no resync mid-frame).
REQ-027 A new start bit SHALL be accepted in the first cycle of IDLE after data_valid (back-to-back frames, no gap required beyond the stop bit).

Reset
REQ-028 While reset == 0 at a rising clk edge: FSM -> IDLE; tick, sample and bit counters -> 0; shift register -> 8'h00.
REQ-029 Reset values: data = 8'h00, data_valid = 0, framing_error = 0, busy = 0; synchronizer flops -> 1 (idle line).
REQ-030 Reset asserted mid-frame SHALL abort the frame with no pulse on data_valid or framing_error; after release, the receiver SHALL wait for a new falling edge.

Verification (CLK_FREQ=1_600_000, BAUD_RATE=10_000 -> DIV=10, 160 clk per bit)
REQ-031 Send 0xA5 (8N1), RxD high otherwise -> exactly one data_valid pulse, data == 8'hA5, framing_error never 1, busy low afterwards.
REQ-032 Send 0x00 then 0xFF back-to-back, one stop bit each -> two data_valid pulses, data 8'h00 then 8'hFF.
REQ-033 RxD low pulse of 40 clk while idle -> no data_valid, busy high for no more than 80+3 clk, then 0.
REQ-034 Send 0x3C with stop bit driven 0, RxD held low 500 more clk -> one framing_error pulse, data keeps its previous value, busy high until RxD returns high.
REQ-035 Assert reset for 2 clk during data bit 4 of 0x5A -> no output pulses, outputs at reset values; following frame 0x81 -> data == 8'h81.
REQ-036 Skew test: send 0xC3 at bit period 150 and at 170 clk -> data == 8'hC3 in both cases.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, oversampled tick generator and
// a five-state FSM that samples each bit at its midpoint and reports framing errors.
module uart_receiver #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE + 1);
  localparam int HALF    = (OVERSAMPLE / 2 > 0) ? OVERSAMPLE / 2 - 1 : 0;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(HALF);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [TW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic            w_tick_clr;
  logic [SW-1:0]   r_samp_cnt;
  logic [SW-1:0]   w_samp_nxt;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      r_data;
  logic [7:0]      w_data_nxt;
  logic            r_dv;
  logic            w_dv_nxt;
  logic            r_fe;
  logic            w_fe_nxt;

  // Synchronizer resets to the idle-line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!reset || w_tick_clr || w_tick) r_tick_cnt <= '0;
    else                                r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // data_valid / framing_error are single-cycle strobes with no ready input:
  // the consumer must capture data in the cycle data_valid is high.
  always_comb begin
    w_state_nxt = r_state;
    w_samp_nxt  = r_samp_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_dv_nxt    = 1'b0;
    w_fe_nxt    = 1'b0;
    w_tick_clr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_samp_nxt  = '0;
          w_bit_nxt   = '0;
          w_tick_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_samp_cnt == HALF_LAST) begin
            w_samp_nxt  = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_samp_nxt = r_samp_cnt + SW'(1);
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_samp_nxt  = '0;
            w_shift_nxt = {r_rx_s, r_shift[7:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
          end else begin
            w_samp_nxt = r_samp_cnt + SW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_samp_nxt = '0;
            if (r_rx_s) begin
              w_data_nxt  = r_shift;
              w_dv_nxt    = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_fe_nxt    = 1'b1;
              w_state_nxt = S_WAIT_IDLE;
            end
          end else begin
            w_samp_nxt = r_samp_cnt + SW'(1);
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= 8'h00;
      r_data     <= 8'h00;
      r_dv       <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_samp_cnt <= w_samp_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_dv       <= w_dv_nxt;
      r_fe       <= w_fe_nxt;
    end
  end

  assign data          = r_data;
  assign data_valid    = r_dv;
  assign framing_error = r_fe;
  assign busy          = (r_state != S_IDLE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are decoded by an ideal
// mid-bit sampling model of the line and checked against the DUT every cycle.
module tb_uart_receiver;

  localparam int BIT      = 160;
  localparam int HALF     = BIT / 2;
  localparam int SYNC_LAT = 3;
  localparam int LAT_MIN  = 9 * BIT;
  localparam int LAT_MAX  = 9 * BIT + HALF + 3;
  localparam int W        = 41;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;
  logic [2:0] dbg_state;

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_dv = 0;
  int         n_fe = 0;
  logic       chk_en = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] head_q;
  int         d_q;

  uart_receiver #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .RxD          (RxD),
    .data         (data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    chk_en = 1'b0;
    reset  = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_data = 8'h00;
    @(negedge clk);
    chk_en = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Line level t clocks after the start edge for a frame sent with period p.
  function automatic logic line_at(int t, logic [7:0] b, int p, logic stop_v);
    int slot;
    slot = t / p;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return stop_v;
  endfunction

  // Ideal receiver: samples mid-bit on a 160-clk grid started at the detected edge.
  function automatic logic [8:0] decode(logic [7:0] b, int p, logic stop_v);
    logic [7:0] v;
    for (int k = 1; k <= 8; k++)
      v[k-1] = line_at(SYNC_LAT + HALF + k * BIT, b, p, stop_v);
    return {line_at(SYNC_LAT + HALF + 9 * BIT, b, p, stop_v), v};
  endfunction

  // ---------------- driver ----------------
  // Leaves RxD low after a bad stop bit; the caller releases the line.
  task automatic drive_frame(input logic [7:0] b, input int p, input logic stop_v, input int hold_low);
    logic [8:0] r;
    r = decode(b, p, stop_v);
    exp_q.push_back({~r[8], r[7:0], 32'(cyc)});
    for (int s = 0; s < 10; s++) begin
      RxD = line_at(s * p, b, p, stop_v);
      repeat (p) @(negedge clk);
    end
    if (stop_v) RxD = 1'b1;
    else repeat (hold_low) @(negedge clk);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (data_valid) n_dv++;
      if (framing_error) n_fe++;
      check("dv_fe_exclusive", 32'(data_valid & framing_error), 32'd0);
      if (data_valid || framing_error) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", {30'd0, data_valid, framing_error}, 32'd0);
        end else begin
          head_q = exp_q.pop_front();
          d_q    = cyc - int'(head_q[31:0]);
          check("pulse_kind_fe", 32'(framing_error), 32'(head_q[40]));
          check("latency_in_window", 32'(d_q >= LAT_MIN && d_q <= LAT_MAX), 32'd1);
          if (data_valid) begin
            check("rx_byte", 32'(data), 32'(head_q[39:32]));
            model_data = head_q[39:32];
          end
        end
      end else if (exp_q.size() != 0) begin
        d_q = cyc - int'(exp_q[0][31:0]);
        if (d_q > LAT_MAX) begin
          check("pulse_timeout", 32'(d_q), 32'(LAT_MAX));
          void'(exp_q.pop_front());
        end else if (d_q > SYNC_LAT && d_q <= LAT_MIN) begin
          check("busy_in_frame", 32'(busy), 32'd1);
        end
      end
      check("data_hold", 32'(data), 32'(model_data));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base_dv;
    int base_fe;
    int hi;
    @(negedge clk);
    apply_reset(4);
    check("rst_data", 32'(data), 32'h00);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // single frame
    base_dv = n_dv; base_fe = n_fe;
    drive_frame(8'hA5, BIT, 1'b1, 0);
    idle(200);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_count", 32'(n_dv - base_dv), 32'd1);
    check("a5_no_fe", 32'(n_fe - base_fe), 32'd0);
    check("a5_busy_low", 32'(busy), 32'd0);

    // back-to-back frames
    base_dv = n_dv;
    drive_frame(8'h00, BIT, 1'b1, 0);
    drive_frame(8'hFF, BIT, 1'b1, 0);
    idle(100);
    check("b2b_count", 32'(n_dv - base_dv), 32'd2);
    check("b2b_last", 32'(data), 32'hFF);

    // start-bit glitch
    base_dv = n_dv; hi = 0;
    RxD = 1'b0;
    repeat (40) begin @(negedge clk); hi += int'(busy); end
    RxD = 1'b1;
    repeat (200) begin @(negedge clk); hi += int'(busy); end
    check("glitch_busy_max", 32'(hi <= 83), 32'd1);
    check("glitch_busy_seen", 32'(hi > 0), 32'd1);
    check("glitch_no_dv", 32'(n_dv - base_dv), 32'd0);
    check("glitch_busy_end", 32'(busy), 32'd0);

    // framing error with line held low
    base_fe = n_fe;
    drive_frame(8'h3C, BIT, 1'b0, 500);
    check("fe_count", 32'(n_fe - base_fe), 32'd1);
    check("fe_busy_hold", 32'(busy), 32'd1);
    check("fe_data_kept", 32'(data), 32'hFF);
    RxD = 1'b1;
    idle(6);
    check("fe_busy_release", 32'(busy), 32'd0);

    // reset in the middle of data bit 4 of 0x5A
    base_dv = n_dv; base_fe = n_fe;
    for (int s = 0; s < 6; s++) begin
      RxD = line_at(s * BIT, 8'h5A, BIT, 1'b1);
      repeat ((s == 5) ? HALF : BIT) @(negedge clk);
    end
    apply_reset(2);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    idle(300);
    check("mid_rst_no_dv", 32'(n_dv - base_dv), 32'd0);
    check("mid_rst_no_fe", 32'(n_fe - base_fe), 32'd0);
    drive_frame(8'h81, BIT, 1'b1, 0);
    idle(100);
    check("post_rst_data", 32'(data), 32'h81);

    // baud skew
    base_dv = n_dv;
    drive_frame(8'hC3, 150, 1'b1, 0);
    idle(100);
    check("skew150_data", 32'(data), 32'hC3);
    drive_frame(8'hC3, 170, 1'b1, 0);
    idle(50);
    check("skew170_data", 32'(data), 32'hC3);
    check("skew_count", 32'(n_dv - base_dv), 32'd2);

    // randomized frames
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      int p;
      int gap;
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        drive_frame(b, BIT, 1'b0, $urandom_range(0, 300));
        RxD = 1'b1;
        idle(4 + $urandom_range(0, 20));
      end else begin
        p   = $urandom_range(155, 165);
        gap = (p < BIT) ? 10 * (BIT - p) + 10 : 0;
        drive_frame(b, p, 1'b1, 0);
        idle(gap + $urandom_range(0, 20));
      end
    end

    hi = 0;
    while (exp_q.size() != 0 && hi < 3000) begin
      @(negedge clk);
      hi++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
